// File: rtl/seq_detect_prog.sv
// Programmable serial bit-pattern detector with a runtime-loadable pattern
// of 1..MAX_LEN bits, selectable overlap and a saturating match counter.
module seq_detect_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011,
  parameter int                 DEF_LEN     = 4,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_inp_bit,
  input  logic               i_inp_valid,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_pattern,
  input  logic [LEN_W-1:0]   i_pat_len,
  input  logic               i_overlap,
  input  logic               i_clear_count,
  output logic               o_seq_seen,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_cfg_err;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic               r_seq_seen;
  logic [CNT_W-1:0]   r_match_count;

  logic               w_accept;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [LEN_W-1:0]   w_fill_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic               w_load_err;

  assign w_accept    = i_inp_valid & ~i_cfg_load;
  assign w_hist_next = {r_hist[MAX_LEN-2:0], i_inp_bit};
  assign w_fill_next = (r_fill == MAX_LEN_L) ? r_fill : r_fill + 1'b1;
  assign w_load_err  = (i_pat_len == '0) || (i_pat_len > MAX_LEN_L);

  // Only the low r_len bits of history and pattern take part in the compare.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (LEN_W'(i) < r_len);
    end
  end

  assign w_match = w_accept & ~r_cfg_err & (w_fill_next >= r_len) &
                   ((w_hist_next & w_mask) == (r_pat & w_mask));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pat     <= DEF_PATTERN;
      r_len     <= DEF_LEN_L;
      r_ovl     <= 1'b1;
      r_cfg_err <= 1'b0;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (i_cfg_load) begin
      r_pat     <= i_pattern;
      r_len     <= i_pat_len;
      r_ovl     <= i_overlap;
      r_cfg_err <= w_load_err;
      r_hist    <= '0;
      r_fill    <= '0;
    end else if (w_accept) begin
      r_hist <= w_hist_next;
      r_fill <= (w_match && !r_ovl) ? '0 : w_fill_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seq_seen    <= 1'b0;
      r_match_count <= '0;
    end else begin
      r_seq_seen <= w_match;
      if (i_clear_count) begin
        r_match_count <= w_match ? CNT_W'(1) : '0;
      end else if (w_match && (r_match_count != CNT_MAX)) begin
        r_match_count <= r_match_count + 1'b1;
      end
    end
  end

  assign o_seq_seen    = r_seq_seen;
  assign o_match_count = r_match_count;
  assign o_cfg_err     = r_cfg_err;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: directed scenarios then random traffic, with two
// DUTs (8-bit and 2-bit counters) sharing stimulus, checked against a model.
module tb_seq_detect_prog;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inp_bit, inp_valid, cfg_load, overlap, clear_count;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic       seen_a, seen_b, err_a, err_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  // model state: bits accepted since last reset/load/non-overlap match
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl, m_err, m_seen;
  int         m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_inp_bit(inp_bit), .i_inp_valid(inp_valid),
    .i_cfg_load(cfg_load), .i_pattern(pattern), .i_pat_len(pat_len),
    .i_overlap(overlap), .i_clear_count(clear_count),
    .o_seq_seen(seen_a), .o_match_count(cnt_a), .o_cfg_err(err_a));

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_inp_bit(inp_bit), .i_inp_valid(inp_valid),
    .i_cfg_load(cfg_load), .i_pattern(pattern), .i_pat_len(pat_len),
    .i_overlap(overlap), .i_clear_count(clear_count),
    .o_seq_seen(seen_b), .o_match_count(cnt_b), .o_cfg_err(err_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pat = 8'b0000_1011; m_len = 4; m_ovl = 1; m_err = 0;
    m_seen = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  function automatic bit tail_matches();
    if (m_err || q.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++)
      if (q[q.size() - 1 - i] != m_pat[i]) return 0;
    return 1;
  endfunction

  task automatic check_all(input string where);
    chk({where, ".seen_a"}, 32'(seen_a), 32'(m_seen));
    chk({where, ".seen_b"}, 32'(seen_b), 32'(m_seen));
    chk({where, ".cnt_a"},  32'(cnt_a),  32'(m_cnt8));
    chk({where, ".cnt_b"},  32'(cnt_b),  32'(m_cnt2));
    chk({where, ".err"},    32'(err_a),  32'(m_err));
  endtask

  task automatic step(input logic b, input logic v, input logic ld,
                      input logic [7:0] p, input logic [3:0] l, input logic o,
                      input logic clr);
    bit match;
    inp_bit = b; inp_valid = v; cfg_load = ld; pattern = p; pat_len = l;
    overlap = o; clear_count = clr;
    @(posedge clk);
    match = 0;
    if (ld) begin
      m_pat = p; m_len = int'(l); m_ovl = o; m_err = (l == 0) || (l > 8);
      q.delete();
    end else if (v) begin
      q.push_back(b);
      if (q.size() > 8) void'(q.pop_front());
      match = tail_matches();
      if (match && !m_ovl) q.delete();
    end
    m_seen = match;
    if (clr) begin
      m_cnt8 = match ? 1 : 0;
      m_cnt2 = match ? 1 : 0;
    end else if (match) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    #1;
    check_all("step");
  endtask

  task automatic bit_in(input logic b);
    step(b, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o);
    step(1'b0, 1'b0, 1'b1, p, l, o, 1'b0);
  endtask

  // send n bits of v, MSB first
  task automatic send(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
  endtask

  task automatic do_reset();
    inp_valid = 0; cfg_load = 0; clear_count = 0;
    #2 rst_n = 0;
    #1;
    model_reset();
    check_all("in_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    inp_bit = 0; inp_valid = 0; cfg_load = 0; pattern = 0; pat_len = 0;
    overlap = 0; clear_count = 0;
    rst_n = 0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // defaults, overlap: pulses after bits 4 and 7
    send(16'b1011011, 7);
    chk("dflt_cnt", 32'(cnt_a), 32'd2);
    idle();

    // non-overlap 1011: one pulse
    load(8'b1011, 4'd4, 1'b0);
    send(16'b1011011, 7);
    chk("novl_cnt", 32'(cnt_a), 32'd3);

    // valid gaps between bits
    load(8'b1011, 4'd4, 1'b1);
    bit_in(1); idle(); idle(); bit_in(0); idle(); bit_in(1); idle(); idle(); bit_in(1);
    chk("gap_seen", 32'(seen_a), 32'd1);
    idle();

    // len 1: three consecutive pulses; counter b saturates, then clear+match
    load(8'b1, 4'd1, 1'b1);
    send(16'b111, 3);
    chk("len1_seen", 32'(seen_a), 32'd1);
    bit_in(1); bit_in(1);
    chk("sat_cnt_b", 32'(cnt_b), 32'd3);
    step(1'b1, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1);
    chk("clr_match", 32'(cnt_b), 32'd1);

    // len MAX_LEN all ones: first pulse after 8th one
    load(8'hFF, 4'd8, 1'b1);
    send(16'b1111111, 7);
    chk("max_early", 32'(seen_a), 32'd0);
    bit_in(1);
    chk("max_hit", 32'(seen_a), 32'd1);
    bit_in(1);

    // illegal length, then recovery
    load(8'b1011, 4'd0, 1'b1);
    chk("err_set", 32'(err_a), 32'd1);
    send(16'b1011011, 7);
    load(8'b1011, 4'd9, 1'b1);
    send(16'b1011, 4);
    load(8'b1011, 4'd4, 1'b1);
    chk("err_clr", 32'(err_a), 32'd0);
    send(16'b1011, 4);

    // load collides with a valid bit: that bit is dropped
    send(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 8'b1011, 4'd4, 1'b1, 1'b0);
    bit_in(1);
    chk("collide", 32'(seen_a), 32'd0);
    send(16'b011, 3);

    // reset mid-pattern
    send(16'b101, 3);
    do_reset();
    bit_in(1);
    chk("rst_nopulse", 32'(seen_a), 32'd0);
    idle();
    send(16'b1011, 4);
    chk("rst_after", 32'(cnt_a), 32'd1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        logic [3:0] l;
        l = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                        : 4'($urandom_range(1, 3));
        load(8'($urandom), l, 1'($urandom));
      end else if (r == 4 && n % 7 == 0) begin
        do_reset();
      end else begin
        step(1'($urandom), (r % 4) != 0, 1'b0, 8'h00, 4'd0, 1'b0, r >= 97);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable serial bit-pattern detector, the parametrised successor to the fixed 1011 detector. It watches a one-bit input stream qualified by a valid strobe and matches it against a runtime-loadable pattern of 1..MAX_LEN bits. Overlapping or non-overlapping matching is selectable. It pulses `seq_seen` on each match and keeps a saturating match count. It sits in the same serial front-end position as the fixed detector and resets to that detector's 1011 behaviour.

## Interface
- MAX_LEN, 8: longest supported pattern in bits (>= 2).
- CNT_W, 8: width of `match_count`.
- DEF_PATTERN, 8'b0000_1011: pattern loaded at reset, right-aligned.
- DEF_LEN, 4: pattern length loaded at reset.
- LEN_W, $clog2(MAX_LEN+1): width of `pat_len` (derived).
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- inp_bit  in  1  serial data bit.
- inp_valid  in  1  `inp_bit` is sampled only when this is high.
- cfg_load  in  1  single-cycle strobe that latches `pattern`, `pat_len` and `overlap`.
- pattern  in  MAX_LEN  new pattern, right-aligned; bit pat_len-1 is the first bit received, bit 0 the last.
- pat_len  in  LEN_W  new pattern length.
- overlap  in  1  1 = overlapping matches, 0 = non-overlapping.
- clear_count  in  1  synchronous clear of `match_count`.
- seq_seen  out  1  registered one-cycle match pulse.
- match_count  out  CNT_W  saturating count of matches.
- cfg_err  out  1  the active configuration is illegal; detection is disabled.

## Operation
- Active config registers: `pat_q`, `len_q`, `ovl_q`.
  - Reset values: DEF_PATTERN, DEF_LEN, 1.
- History shift register `hist` (MAX_LEN bits) and fill counter `fill` (0..MAX_LEN, saturating).
- On an accepted bit (inp_valid=1, cfg_load=0):
  - hist_next = {hist[MAX_LEN-2:0], inp_bit}.
  - fill_next = min(fill+1, MAX_LEN).
- Match condition: accepted bit, cfg_err=0, fill_next >= len_q, and hist_next[len_q-1:0] == pat_q[len_q-1:0].
- On a match:
  - `seq_seen` goes high the next cycle for exactly one cycle.
  - `match_count` increments, saturating at 2^CNT_W-1.
- After a match, `ovl_q` selects what happens next:
  - ovl_q=1: history is kept, so a suffix of this match may begin the next match.
  - ovl_q=0: `fill` is cleared to 0, so the next match needs len_q fresh bits.
- inp_valid=0: `hist` and `fill` hold, and `seq_seen` is 0 the next cycle.
- cfg_load=1 does all of the following in the same cycle:
  - Loads the config registers.
  - Clears `hist` and `fill`.
  - Drops any `inp_bit` presented that cycle (load wins).
  - Leaves `match_count` unchanged.
- `cfg_err` is registered. It is 1 when the loaded pat_len == 0 or pat_len > MAX_LEN.
  - While `cfg_err` is 1, bits still shift but no match is declared.
  - It clears only on a legal `cfg_load` or on reset.
- clear_count and a match in the same cycle: `match_count` becomes 1.
- Reset (asynchronous, any time, including mid-pattern):
  - Outputs: seq_seen=0, match_count=0, cfg_err=0.
  - Internal: hist=0, fill=0, config = defaults.
  - A partially received pattern is discarded.

## Timing
- Latency: the last bit of a pattern is sampled at edge N; `seq_seen` is high from edge N to edge N+1. This matches the fixed detector, whose state reaches SEQ_1011 one edge after the final bit.
- `match_count` updates at the same edge that `seq_seen` rises.
- A new configuration takes effect for the bits accepted at edge N+1 and later, where edge N samples `cfg_load`.
- `cfg_err` is valid from edge N+1 after the load.
- Back-to-back matches on consecutive accepted bits are possible when ovl_q=1 (e.g. pattern 11); `seq_seen` then stays high across consecutive cycles.
- No combinational path from inputs to outputs.
- Reset deassertion is synchronised externally. The first accepted bit is the first edge with reset high.

## Test plan
- Defaults, overlap: stream 1,0,1,1,0,1,1 (valid every cycle) -> `seq_seen` pulses after bits 4 and 7; match_count=2.
- Non-overlap: load pattern 1011, len 4, overlap=0; same stream -> one pulse after bit 4; match_count=1.
- Valid gaps and min/max length:
  - Pattern 1011 with inp_valid=0 cycles inserted between its bits -> one pulse after the 4th valid bit; history holds across the gaps.
  - len=1, pattern 1, stream 1,1,1 -> `seq_seen` high for 3 consecutive cycles.
  - len=MAX_LEN with an all-ones pattern -> first pulse only after MAX_LEN ones.
- Config errors and load collision:
  - Load pat_len=0 -> cfg_err=1, the default stream gives no pulses; then load len 4 -> cfg_err=0 and detection resumes.
  - cfg_load in the same cycle as a valid bit -> that bit is ignored.
- Counter: CNT_W=2, five matches -> match_count saturates at 3; clear_count together with a match -> match_count=1.
- Reset mid-pattern: stream 1,0,1, then assert reset, release, then send 1 -> no pulse; outputs read 0 during reset; the next full 1011 -> one pulse.
